// File: rtl/io_bridge_pkg.sv
// Shared constants and helpers for the io_bridge host/processor I/O endpoint.
package io_bridge_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy counter needs one extra bit so that "full" (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small FIFO with an asynchronous-read head: a pushed word is on head the cycle after the push edge.
module io_fifo
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    // Push is refused when full and pop when empty, so a simultaneous pair at either extreme
    // degenerates to the single legal operation.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is deliberately left out of reset; stale contents are hidden by the empty mask.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/io_bridge.sv
// Host <-> processor I/O endpoint: input FIFO feeding read_in, output FIFO draining to the host.
// Define IO_BRIDGE_OVERFLOW_EN to add a sticky overflow flag for writes dropped while out_full.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             host_in_valid,
    input  logic [WIDTH-1:0] host_in_data,
    output logic             host_in_ready,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] read_in,
    output logic             in_avail,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             out_full,
    output logic             host_out_valid,
    output logic [WIDTH-1:0] host_out_data,
    input  logic             host_out_ready
`ifdef IO_BRIDGE_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    logic in_empty;
    logic in_full;
    logic out_empty;

    // Ready/full come straight from registered counts, never from the pop side.
    assign host_in_ready  = !in_full;
    assign in_avail       = !in_empty;
    assign host_out_valid = !out_empty;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (host_in_valid && host_in_ready),
        .pop   (cpu_rd && in_avail),
        .din   (host_in_data),
        .head  (read_in),
        .empty (in_empty),
        .full  (in_full)
    );

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (cpu_wr && !out_full),
        .pop   (host_out_valid && host_out_ready),
        .din   (cpu_wdata),
        .head  (host_out_data),
        .empty (out_empty),
        .full  (out_full)
    );

`ifdef IO_BRIDGE_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (cpu_wr && out_full) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped I/O endpoint on the far side of the processor's `read_in` / `write_out` path. It buffers words arriving from an external host into an input FIFO and presents the head word to the processor as `read_in`. It captures processor output writes into an output FIFO that drains to the host over a valid/ready handshake. It is instantiated beside the processor top, with `read_in` wired straight into the processor's memory component.

## Interface
Parameters:
- `WIDTH`, 16, data word width (matches processor word).
- `DEPTH`, 4, entries per FIFO; must be a power of two, at least 2.

Ports (one clock, `clock`; reset `rst` is asynchronous and active-high):
- `clock`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_in_valid`  in  1  host offers `host_in_data`.
- `host_in_data`  in  WIDTH  word from host.
- `host_in_ready`  out  1  input FIFO not full.
- `cpu_rd`  in  1  processor consumes the current `read_in` word (one-cycle pulse).
- `read_in`  out  WIDTH  head of input FIFO; 0 when empty.
- `in_avail`  out  1  input FIFO non-empty.
- `cpu_wr`  in  1  processor output write strobe.
- `cpu_wdata`  in  WIDTH  processor output word.
- `out_full`  out  1  output FIFO full.
- `host_out_valid`  out  1  output FIFO non-empty.
- `host_out_data`  out  WIDTH  head of output FIFO; 0 when empty.
- `host_out_ready`  in  1  host accepts `host_out_data`.
- `overflow`  out  1  sticky drop flag (present only with `IO_BRIDGE_OVERFLOW_EN`).

## Operation
- Each FIFO holds a read pointer and a write pointer, each log2(DEPTH) bits and wrapping modulo DEPTH. It also holds a count of log2(DEPTH)+1 bits. Full means count==DEPTH; empty means count==0.
- Input push occurs when `host_in_valid && host_in_ready`.
- Input pop occurs when `cpu_rd && in_avail`. `cpu_rd` while empty is ignored and leaves no state change.
- Output push occurs when `cpu_wr && !out_full`. `cpu_wr` while full drops the word. With the macro defined, the drop also sets `overflow`.
- Output pop occurs when `host_out_valid && host_out_ready`.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur and count is unchanged.
- Simultaneous push and pop on an empty FIFO: only the push occurs.
- Simultaneous push and pop on a full FIFO: only the pop occurs.
- `host_in_ready` and `out_full` depend on registered count only. There is no combinational path from any pop input.
- Data ordering is strict FIFO. No word is duplicated or reordered across pointer wrap.

## Timing
- Reset values:
  - All pointers and counts are 0.
  - `read_in` = 0, `in_avail` = 0, `host_in_ready` = 1.
  - `out_full` = 0, `host_out_valid` = 0, `host_out_data` = 0.
  - `overflow` = 0.
- Storage contents are not reset; outputs are masked to 0 when the FIFO is empty.
- Latency: a push accepted at edge N is visible on the head outputs from edge N onward, i.e. one cycle, with no fall-through.
- A pop at edge N exposes the next entry from edge N.
- Reset asserted mid-transfer discards all buffered words immediately and asynchronously. The first post-reset push lands in entry 0.
- The `overflow` flag is cleared only by `rst`.

## Configuration
- `IO_BRIDGE_OVERFLOW_EN` defined: the `overflow` port exists, and it is set on the edge where `cpu_wr` arrives while `out_full` is high.
- `IO_BRIDGE_OVERFLOW_EN` undefined: the port and its register are absent, and dropped writes are silent. All other behaviour is identical.

## Structure
- Package `io_bridge_pkg` holds:
  - default `WIDTH`/`DEPTH` constants;
  - a count-width function `cnt_w(depth) = $clog2(depth)+1`.
- Sub-module `io_fifo` (parameters WIDTH and DEPTH; push, pop, data in, head, empty, full) is instantiated twice, once for input and once for output.
- The top handles only handshake gating and the overflow flag.

## Test plan
- Reset, then 3 host pushes of 0x1111, 0x2222, 0x3333 → `read_in` = 0x1111 with `in_avail` = 1; three `cpu_rd` pulses yield 0x2222, 0x3333, then 0 with `in_avail` = 0.
- Push 4 words with DEPTH = 4 → `host_in_ready` = 0; a fifth `host_in_valid` is not accepted. A same-cycle `cpu_rd` and push at full → only the pop occurs, and `host_in_ready` = 1 the next cycle.
- Hold `host_out_ready` = 0 and issue 5 `cpu_wr` of 0xA000+i → `out_full` = 1 after 4 writes, `overflow` = 1 after the 5th (macro on). Draining then yields 0xA000 through 0xA003 only.
- Run 10 interleaved push/pop cycles through both FIFOs → order is preserved across pointer wrap, and count never exceeds 4 or goes negative.
- Assert `rst` mid-cycle with 2 words buffered in each FIFO → all outputs return to reset values immediately, and a post-reset push of 0x00FF appears on `read_in` as the only entry.
- `cpu_rd` while empty → no change, and `read_in` stays 0.
